ex_muldiv_ctrl: RTL and testbench

//  Sequencer for an iterative multiply/divide unit attached to the LC-3b EX stage.
//  - Accepts MUL/DIV/MOD ops decoded into the control word; computes them over WIDTH cycles

---
 rtl/ex_muldiv_ctrl_pkg.sv | 29 ++
 rtl/ex_muldiv_ctrl_if.sv | 27 ++
 rtl/ex_muldiv_step.sv | 49 ++++
 rtl/ex_muldiv_ctrl.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg: shared types for the EX-stage iterative multiply/divide unit.
//   lc3b_muldiv_op  : operation encoding carried in the control word (3 reserved, runs as MUL)
//   ctrl_muldiv_t   : control-word slice that drives the unit
//   md_state_e      : sequencer states
//   is_div_op()     : true for the ops that use the restoring-divide path
package ex_muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_MOD = 2'd2
    } lc3b_muldiv_op;

    typedef struct packed {
        logic          muldiv_en;
        lc3b_muldiv_op muldiv_op;
    } ctrl_muldiv_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } md_state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_MOD);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: EX-stage <-> multiply/divide unit signal bundle.
//   master (EX stage)  drives start, op, a, b, stall_in, flush
//   slave  (muldiv)    drives stall_req, done, result, div_by_zero
interface ex_muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall_in;
    logic             flush;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, stall_in, flush,
        input  stall_req, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b, stall_in, flush,
        output stall_req, done, result, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one combinational iteration of the multiply/divide engine.
//   i_is_div        : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_opa / o_opa   : MUL multiplicand shift register / DIV dividend shift register
//   i_opb / o_opb   : MUL multiplier shift register  / DIV divisor (unchanged)
//   i_acc / o_acc   : MUL product accumulator        / DIV partial remainder
//   i_quot / o_quot : DIV quotient shift register (passed through for MUL)
module ex_muldiv_step
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_quot,
    output logic [WIDTH-1:0] o_opa,
    output logic [WIDTH-1:0] o_opb,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_quot
);
    // The shifted remainder keeps one extra bit so divisors above 2^(WIDTH-1) still compare
    // correctly; after subtraction the remainder is below the divisor and fits WIDTH bits.
    logic [WIDTH:0]   w_rem_ext;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_sub;

    always_comb begin
        w_rem_ext = {i_acc, i_opa[WIDTH-1]};
        w_fits    = (w_rem_ext >= {1'b0, i_opb});
        w_rem_sub = w_rem_ext[WIDTH-1:0] - i_opb;

        o_opa  = i_opa << 1;
        o_opb  = i_opb;
        o_acc  = i_acc;
        o_quot = i_quot;

        if (i_is_div) begin
            o_acc  = w_fits ? w_rem_sub : w_rem_ext[WIDTH-1:0];
            o_quot = {i_quot[WIDTH-2:0], w_fits};
        end else begin
            if (i_opb[0]) begin
                o_acc = i_acc + i_opa;
            end
            o_opb = i_opb >> 1;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: sequencer for the iterative MUL/DIV/MOD unit in the LC-3b EX stage.
// Accepts an op in IDLE, iterates WIDTH cycles in RUN, presents the result in DONE and
// holds the pipeline through stall_req until then.
//   i_clk      : system clock
//   i_reset_n  : asynchronous active-low reset
//   io_md      : slave side of ex_muldiv_ctrl_if (start/op/a/b/stall_in/flush in,
//                stall_req/done/result/div_by_zero out)
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    ex_muldiv_ctrl_if.slave        io_md
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CountInit = CW'(WIDTH - 1);

    md_state_e        r_state, w_state_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic [1:0]       r_op, w_op_next;
    logic [WIDTH-1:0] r_opa, w_opa_next;
    logic [WIDTH-1:0] r_opb, w_opb_next;
    logic [WIDTH-1:0] r_acc, w_acc_next;
    logic [WIDTH-1:0] r_quot, w_quot_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic             r_dbz, w_dbz_next;

    logic             w_accept;
    logic             w_in_dbz;
    logic             w_stall_req;
    logic [WIDTH-1:0] w_step_opa, w_step_opb, w_step_acc, w_step_quot;

    ex_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (is_div_op(r_op)),
        .i_opa    (r_opa),
        .i_opb    (r_opb),
        .i_acc    (r_acc),
        .i_quot   (r_quot),
        .o_opa    (w_step_opa),
        .o_opb    (w_step_opb),
        .o_acc    (w_step_acc),
        .o_quot   (w_step_quot)
    );

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_op_next     = r_op;
        w_opa_next    = r_opa;
        w_opb_next    = r_opb;
        w_acc_next    = r_acc;
        w_quot_next   = r_quot;
        w_result_next = r_result;
        w_dbz_next    = r_dbz;
        w_stall_req   = 1'b0;

        w_accept = io_md.start & ~io_md.flush;
        w_in_dbz = is_div_op(io_md.op) && (io_md.b == '0);

        unique case (r_state)
            StIdle: begin
                w_stall_req = w_accept;
                if (w_accept) begin
                    w_op_next    = io_md.op;
                    w_opa_next   = io_md.a;
                    w_opb_next   = io_md.b;
                    w_acc_next   = '0;
                    w_quot_next  = '0;
                    w_count_next = CountInit;
                    if (w_in_dbz) begin
                        // Skip the iterations: DIV saturates to all ones, MOD returns a.
                        w_result_next = (io_md.op == MD_DIV) ? '1 : io_md.a;
                        w_dbz_next    = 1'b1;
                        w_state_next  = StDone;
                    end else begin
                        w_state_next = StRun;
                    end
                end
            end
            StRun: begin
                w_stall_req  = 1'b1;
                w_opa_next   = w_step_opa;
                w_opb_next   = w_step_opb;
                w_acc_next   = w_step_acc;
                w_quot_next  = w_step_quot;
                w_count_next = r_count - 1'b1;
                if (r_count == '0) begin
                    // MUL (and reserved op) and MOD both finish in the accumulator.
                    w_result_next = (r_op == MD_DIV) ? w_step_quot : w_step_acc;
                    w_state_next  = StDone;
                end
            end
            StDone: begin
                if (!io_md.stall_in) begin
                    w_dbz_next   = 1'b0;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (io_md.flush) begin
            w_state_next = StIdle;
            w_dbz_next   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_op     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_quot   <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_op     <= w_op_next;
            r_opa    <= w_opa_next;
            r_opb    <= w_opb_next;
            r_acc    <= w_acc_next;
            r_quot   <= w_quot_next;
            r_result <= w_result_next;
            r_dbz    <= w_dbz_next;
        end
    end

    assign io_md.stall_req   = w_stall_req;
    assign io_md.done        = (r_state == StDone);
    assign io_md.result      = r_result;
    assign io_md.div_by_zero = r_dbz;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: self-checking bench for ex_muldiv_ctrl (WIDTH=16).
// Directed vector table, randomized ops against an arithmetic reference model, and
// hand-written sequences for stall-hold, flush and asynchronous reset.
module tb_ex_muldiv_ctrl;
    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ex_muldiv_ctrl_if #(.WIDTH(W)) md ();

    ex_muldiv_ctrl #(
        .WIDTH (W)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .io_md     (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        dbz;
        int          lat;
        int          hold;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the operation definitions.
    function automatic logic [15:0] model_res(input logic [1:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int unsigned p;
        case (op)
            2'd1: return (b == 0) ? 16'hFFFF : a / b;
            2'd2: return (b == 0) ? a : a % b;
            default: begin
                p = a * b;
                return p[15:0];
            end
        endcase
    endfunction

    function automatic logic model_dbz(input logic [1:0] op, input logic [15:0] b);
        return (op == 2'd1 || op == 2'd2) && (b == 0);
    endfunction

    // Call in an IDLE cycle (just after a posedge). Returns in the following IDLE cycle.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_dbz, input int exp_lat,
                          input int hold, input string name);
        int edges;
        int stall_cnt;
        logic [15:0] held;
        md.start    = 1'b1;
        md.op       = op;
        md.a        = a;
        md.b        = b;
        md.flush    = 1'b0;
        md.stall_in = (hold != 0);
        #1;
        edges     = 0;
        stall_cnt = 0;
        while (!md.done && edges < 100) begin
            if (md.stall_req) stall_cnt++;
            @(posedge clk);
            #1;
            edges++;
            // Operands must not be re-sampled once accepted.
            md.start = 1'b0;
            md.op    = 2'($urandom);
            md.a     = 16'($urandom);
            md.b     = 16'($urandom);
            #1;
        end
        check({name, " done"}, 32'(md.done), 32'd1);
        check({name, " latency"}, 32'(edges), 32'(exp_lat));
        check({name, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({name, " result"}, 32'(md.result), 32'(exp_res));
        check({name, " dbz"}, 32'(md.div_by_zero), 32'(exp_dbz));
        check({name, " stall_req_done"}, 32'(md.stall_req), 32'd0);
        held = md.result;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({name, " hold_done"}, 32'(md.done), 32'd1);
            check({name, " hold_result"}, 32'(md.result), 32'(held));
            check({name, " hold_dbz"}, 32'(md.div_by_zero), 32'(exp_dbz));
        end
        md.stall_in = 1'b0;
        @(posedge clk);
        #1;
        check({name, " idle_done"}, 32'(md.done), 32'd0);
        check({name, " idle_dbz"}, 32'(md.div_by_zero), 32'd0);
    endtask

    initial begin
        int seen_done;
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{2'd0, 16'd7,    16'd9,    16'h003F, 1'b0, 17, 0, "mul_7x9"};
        vecs[1]  = '{2'd0, 16'h1234, 16'h0010, 16'h2340, 1'b0, 17, 0, "mul_trunc"};
        vecs[2]  = '{2'd1, 16'd100,  16'd7,    16'd14,   1'b0, 17, 0, "div_100_7"};
        vecs[3]  = '{2'd2, 16'd100,  16'd7,    16'd2,    1'b0, 17, 0, "mod_100_7"};
        vecs[4]  = '{2'd1, 16'd5,    16'd0,    16'hFFFF, 1'b1, 1,  0, "div_by_0"};
        vecs[5]  = '{2'd2, 16'd5,    16'd0,    16'd5,    1'b1, 1,  3, "mod_by_0_hold"};
        vecs[6]  = '{2'd0, 16'd7,    16'd9,    16'h003F, 1'b0, 17, 3, "mul_hold"};
        vecs[7]  = '{2'd1, 16'hFFFF, 16'h8000, 16'd1,    1'b0, 17, 0, "div_big"};
        vecs[8]  = '{2'd2, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 17, 0, "mod_big"};
        vecs[9]  = '{2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17, 0, "mul_max"};
        vecs[10] = '{2'd3, 16'd3,    16'd5,    16'd15,   1'b0, 17, 0, "rsvd_as_mul"};
        vecs[11] = '{2'd1, 16'd3,    16'd10,   16'd0,    1'b0, 17, 0, "div_small"};

        // Reset state
        rst_n       = 1'b0;
        md.start    = 1'b0;
        md.op       = 2'd0;
        md.a        = '0;
        md.b        = '0;
        md.stall_in = 1'b0;
        md.flush    = 1'b0;
        #12;
        check("rst_done", 32'(md.done), 32'd0);
        check("rst_result", 32'(md.result), 32'd0);
        check("rst_dbz", 32'(md.div_by_zero), 32'd0);
        check("rst_stall_idle", 32'(md.stall_req), 32'd0);
        md.start = 1'b1;
        #1;
        check("rst_stall_start", 32'(md.stall_req), 32'd1);
        md.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, back-to-back
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz,
                   vecs[i].lat, vecs[i].hold, vecs[i].name);
        end

        // Randomized against reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> ($urandom_range(0, 15)));
            run_op(rop, ra, rb, model_res(rop, ra, rb), model_dbz(rop, rb),
                   model_dbz(rop, rb) ? 1 : 17, int'($urandom_range(0, 2)), "rand");
        end

        // flush overrides start in IDLE
        md.start = 1'b1;
        md.flush = 1'b1;
        md.op    = 2'd0;
        md.a     = 16'd3;
        md.b     = 16'd3;
        #1;
        check("flush_start_stall", 32'(md.stall_req), 32'd0);
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.flush = 1'b0;
        #1;
        check("flush_start_idle", 32'(md.stall_req), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (md.done) seen_done++;
        end
        check("flush_start_no_done", 32'(seen_done), 32'd0);

        // flush at T+5 of a MUL
        md.start = 1'b1;
        md.op    = 2'd0;
        md.a     = 16'd7;
        md.b     = 16'd9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            md.start = 1'b0;
        end
        md.flush = 1'b1;
        #1;
        check("flush_run_stall", 32'(md.stall_req), 32'd1);
        @(posedge clk);
        #1;
        md.flush = 1'b0;
        #1;
        check("flush_idle_stall", 32'(md.stall_req), 32'd0);
        check("flush_idle_done", 32'(md.done), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (md.done) seen_done++;
        end
        check("flush_no_done", 32'(seen_done), 32'd0);

        // reset_n pulse at T+8 of a MUL; result still holds an earlier nonzero value
        check("pre_reset_result_nonzero", 32'(md.result != 0), 32'd1);
        md.start = 1'b1;
        md.op    = 2'd0;
        md.a     = 16'd7;
        md.b     = 16'd9;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            md.start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", 32'(md.stall_req), 32'd0);
        check("async_rst_done", 32'(md.done), 32'd0);
        check("async_rst_result", 32'(md.result), 32'd0);
        check("async_rst_dbz", 32'(md.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (md.done || md.stall_req || md.result != 0) seen_done++;
        end
        check("post_rst_quiet", 32'(seen_done), 32'd0);

        // Fresh op after reset still works
        run_op(2'd1, 16'd100, 16'd7, 16'd14, 1'b0, 17, 0, "post_rst_div");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
